// File: rtl/tinker_fetch_unit.sv
// Tinker fetch front end: one outstanding 32-bit read, 2-entry {pc,word} buffer, redirect squash.
// A response in cycle N is visible at N+1. Fetch parks in IDLE while the buffer is full.
module tinker_fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h2000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [63:0] mem_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [63:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] req_addr_q, req_addr_d;
   logic        squash_q, squash_d;
   logic [1:0]  count_q, count_d;
   logic [63:0] pc0_q, pc0_d, pc1_q, pc1_d;
   logic [31:0] word0_q, word0_d, word1_q, word1_d;
   logic        accept, push, pop;

   assign accept = (state_q == ST_REQ) && mem_req_ready;
   assign push   = (state_q == ST_WAIT) && mem_rsp_valid && !squash_q && !redirect_valid;
   assign pop    = instr_valid && instr_ready;

   always_comb begin
      count_d = count_q;
      if (redirect_valid) begin
         count_d = 2'd0;
      end else begin
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // Entry 0 is the head; a push lands in whichever slot is free after this cycle's pop.
   always_comb begin
      pc0_d   = pc0_q;
      word0_d = word0_q;
      pc1_d   = pc1_q;
      word1_d = word1_q;
      if (pop) begin
         pc0_d   = pc1_q;
         word0_d = word1_q;
      end
      if (push) begin
         if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
            pc0_d   = req_addr_q;
            word0_d = mem_rsp_data;
         end else begin
            pc1_d   = req_addr_q;
            word1_d = mem_rsp_data;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      squash_d   = squash_q;
      req_addr_d = req_addr_q;
      // A squashed request must not advance the PC, it already points past the redirect.
      if (accept && !squash_q && !redirect_valid) begin
         pc_d = pc_q + 64'd4;
      end
      if (redirect_valid) begin
         pc_d = {redirect_pc[63:2], 2'b00};
      end
      case (state_q)
         ST_IDLE: begin
            if (count_d < 2'd2) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (redirect_valid) squash_d = 1'b1;
            if (mem_req_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_rsp_valid) begin
               squash_d = 1'b0;
               state_d  = (count_d < 2'd2) ? ST_REQ : ST_IDLE;
            end else if (redirect_valid) begin
               squash_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if ((state_d == ST_REQ) && (state_q != ST_REQ)) begin
         req_addr_d = pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= 64'd0;
         squash_q   <= 1'b0;
         count_q    <= 2'd0;
         pc0_q      <= 64'd0;
         pc1_q      <= 64'd0;
         word0_q    <= 32'd0;
         word1_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         squash_q   <= squash_d;
         count_q    <= count_d;
         pc0_q      <= pc0_d;
         pc1_q      <= pc1_d;
         word0_q    <= word0_d;
         word1_q    <= word1_d;
      end
   end

   assign mem_req_valid = (state_q == ST_REQ);
   assign mem_addr      = req_addr_q;
   assign instr_valid   = (count_q != 2'd0);
   assign instruction   = word0_q;
   assign instr_pc      = pc0_q;

endmodule
